// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks.
//   TAPS_DEF   : products summed per output window
//   PROD_W_DEF : width of the signed product from the upstream multiplier
//   ACC_W_DEF  : accumulator width
//   SHIFT_DEF  : requantisation right-shift
//   acc_state_e: conv_accum FSM state encoding
package cnn_pkg;

    localparam int TAPS_DEF   = 9;
    localparam int PROD_W_DEF = 16;
    // Nine full-scale 16-bit products plus the largest shifted bias and the
    // rounding constant still fit in 20 signed bits, so 20 is enough here.
    localparam int ACC_W_DEF  = 20;
    localparam int SHIFT_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/requant_relu.sv
// Combinational requantiser: round-half-up arithmetic right shift, then
// ReLU and saturation to an unsigned byte.
//   sum  : signed ACC_W-bit window sum (bias already folded in)
//   data : unsigned 8-bit result
module requant_relu
    import cnn_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [7:0]       data
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int EW    = ACC_W + 1;
    localparam int RND_I = (SHIFT > 0) ? (2 ** (SHIFT - 1)) : 0;
    localparam logic signed [EW-1:0] RND  = EW'(RND_I);
    localparam logic signed [EW-1:0] MAXV = EW'(255);

    function automatic logic signed [EW-1:0] round_shift(
        input logic signed [ACC_W-1:0] s
    );
        logic signed [EW-1:0] t;
        t = {s[ACC_W-1], s};
        t = t + RND;
        return t >>> SHIFT;
    endfunction

    function automatic logic [7:0] relu_sat(input logic signed [EW-1:0] r);
        logic [7:0] res;
        if (r < 0) begin
            res = 8'd0;
        end else if (r > MAXV) begin
            res = 8'hFF;
        end else begin
            res = r[7:0];
        end
        return res;
    endfunction

    assign data = relu_sat(round_shift(sum));

endmodule

// File: rtl/conv_accum.sv
// Convolution window accumulator. Sums TAPS signed products (seeded with a
// per-window bias), requantises the final sum and holds the byte result
// under a valid/ready handshake until downstream takes it.
//   clock, aclr (sync, active-high), clken (freezes all state when 0)
//   prod / prod_valid / in_ready : product stream from the registered
//                                  lpm_mult result
//   bias                         : signed bias, sampled on the first tap
//   out_data / out_valid / out_ready : requantised ReLU output handshake
//   tap_cnt                      : products accepted in the current window
module conv_accum
    import cnn_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int SHIFT  = SHIFT_DEF
) (
    input  logic                          clock,
    input  logic                          aclr,
    input  logic                          clken,
    input  logic [PROD_W-1:0]             prod,
    input  logic                          prod_valid,
    output logic                          in_ready,
    input  logic [7:0]                    bias,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(TAPS+1)-1:0]     tap_cnt
);

    localparam int CW = $clog2(TAPS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(TAPS - 1);

    acc_state_e              state_p0, state_n;
    logic signed [ACC_W-1:0] acc_p0, acc_n;
    logic        [CW-1:0]    cnt_n;
    logic        [7:0]       data_n;
    logic                    vld_n;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum_p0;
    logic        [7:0]       rq_data;
    logic                    finish;

    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-8){bias[7]}}, bias};

    // The first tap seeds the sum with the bias scaled into accumulator
    // units; later taps add onto the running sum.
    assign base   = (state_p0 == ST_IDLE) ? (bias_ext <<< SHIFT) : acc_p0;
    assign sum_p0 = base + prod_ext;

    // The result is formed from the final sum in the same cycle as the last
    // tap, so the output register is the only latency.
    requant_relu #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .sum  (sum_p0),
        .data (rq_data)
    );

    always_comb begin
        state_n  = state_p0;
        acc_n    = acc_p0;
        cnt_n    = tap_cnt;
        data_n   = out_data;
        vld_n    = out_valid;
        finish   = 1'b0;
        in_ready = (state_p0 != ST_HOLD);

        if (clken) begin
            unique case (state_p0)
                ST_IDLE: begin
                    if (prod_valid) begin
                        acc_n = sum_p0;
                        if (TAPS == 1) begin
                            finish = 1'b1;
                        end else begin
                            cnt_n   = CW'(1);
                            state_n = ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    if (prod_valid) begin
                        acc_n = sum_p0;
                        if (tap_cnt == LAST_IDX) begin
                            finish = 1'b1;
                        end else begin
                            cnt_n = tap_cnt + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        vld_n   = 1'b0;
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase

            if (finish) begin
                data_n  = rq_data;
                vld_n   = 1'b1;
                cnt_n   = '0;
                state_n = ST_HOLD;
            end
        end
    end

    // ---- stage p0: window state and output register ----
    always_ff @(posedge clock) begin
        if (aclr) begin
            state_p0  <= ST_IDLE;
            acc_p0    <= '0;
            tap_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_p0  <= state_n;
            acc_p0    <= acc_n;
            tap_cnt   <= cnt_n;
            out_valid <= vld_n;
            out_data  <= data_n;
        end
    end

endmodule

// File: tb/tb_conv_accum.sv
module tb_conv_accum;

    localparam int TAPS   = 9;
    localparam int PROD_W = 16;
    localparam int ACC_W  = 20;
    localparam int SHIFT  = 4;
    localparam int CW     = $clog2(TAPS + 1);

    logic              clock = 1'b0;
    logic              aclr;
    logic              clken;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              in_ready;
    logic [7:0]        bias;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     tap_cnt;

    conv_accum #(
        .TAPS   (TAPS),
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clock      (clock),
        .aclr       (aclr),
        .clken      (clken),
        .prod       (prod),
        .prod_valid (prod_valid),
        .in_ready   (in_ready),
        .bias       (bias),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tap_cnt    (tap_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int data;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_exp_out = 0;
    int   n_out     = 0;
    int   cyc       = 0;
    int   first_cyc = 0;
    int   last_cyc  = 0;
    int   win[TAPS];

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: bias scaled by 2^SHIFT, round half up, ReLU, clamp to a byte.
    function automatic int model(input int b, input int s_prod);
        int s;
        int r;
        s = b * (2 ** SHIFT) + s_prod;
        r = (s + 2 ** (SHIFT - 1)) >>> SHIFT;
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    task automatic fill(input int v);
        for (int i = 0; i < TAPS; i++) win[i] = v;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Output monitor: pops the scoreboard when out_valid rises and checks
    // the result stays put while it is held.
    initial begin
        bit         ov_seen;
        logic [7:0] held;
        exp_t       e;
        ov_seen = 1'b0;
        held    = '0;
        forever begin
            @(negedge clock);
            if (out_valid && !ov_seen) begin
                ov_seen = 1'b1;
                held    = out_data;
                n_out++;
                check_val("in_ready_on_valid", int'(in_ready), 0);
                if (sb.size() == 0) begin
                    check_val("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("out_data", int'(out_data), e.data);
                    check_val("window_latency", cyc - first_cyc, e.lat);
                    check_val("last_tap_latency", cyc - last_cyc, 1);
                end
            end else if (out_valid) begin
                check_val("hold_stable", int'(out_data), int'(held));
                check_val("hold_in_ready", int'(in_ready), 0);
            end else begin
                ov_seen = 1'b0;
            end
        end
    end

    // Drives ntaps products of win[]; optional random gaps between taps and a
    // three-cycle clken stall before tap stall_at. Pushes the expectation
    // when the window is complete and push is set.
    task automatic send_window(input int b, input int ntaps, input int stall_at,
                               input bit gaps, input bit push);
        int  extra;
        int  tries;
        int  g;
        int  psum;
        bit  accepted;
        exp_t e;
        extra = 0;
        psum  = 0;
        for (int k = 0; k < ntaps; k++) begin
            if (gaps && k > 0) begin
                g = int'($urandom_range(0, 2));
                for (int j = 0; j < g; j++) begin
                    @(negedge clock);
                    prod_valid = 1'b0;
                    prod       = PROD_W'($urandom);
                    extra++;
                end
            end
            if (k == stall_at) begin
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    clken      = 1'b0;
                    prod_valid = 1'b1;
                    prod       = PROD_W'($urandom);
                    extra++;
                end
            end
            accepted = 1'b0;
            tries    = 0;
            while (!accepted && tries < 40) begin
                @(negedge clock);
                clken      = 1'b1;
                prod       = PROD_W'(win[k]);
                prod_valid = 1'b1;
                bias       = (k == 0) ? 8'(b) : 8'($urandom);
                if (in_ready) accepted = 1'b1;
                tries++;
            end
            if (!accepted) begin
                check_val("tap_accept_timeout", 0, 1);
                prod_valid = 1'b0;
                return;
            end
            if (k == 0) first_cyc = cyc;
            if (k == ntaps - 1) last_cyc = cyc;
            psum += win[k];
        end
        if (push) begin
            e.data = model(b, psum);
            e.lat  = TAPS + extra;
            sb.push_back(e);
            n_exp_out++;
        end
        @(negedge clock);
        prod_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i;
        i = 0;
        while (!out_valid && i < 40) begin
            @(negedge clock);
            i++;
        end
        if (!out_valid) check_val(tag, 0, 1);
    endtask

    initial begin
        int b;
        aclr       = 1'b1;
        clken      = 1'b1;
        prod       = '0;
        prod_valid = 1'b0;
        bias       = '0;
        out_ready  = 1'b1;

        repeat (3) @(negedge clock);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_out_data", int'(out_data), 0);
        check_val("rst_tap_cnt", int'(tap_cnt), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        aclr = 1'b0;

        // Basic windows: plain sum, bias, ReLU, saturation.
        fill(16);      send_window(0, TAPS, -1, 1'b0, 1'b1);
        fill(16);      send_window(2, TAPS, -1, 1'b0, 1'b1);
        fill(-16);     send_window(0, TAPS, -1, 1'b0, 1'b1);
        fill(32'h7FFF); send_window(0, TAPS, -1, 1'b0, 1'b1);
        fill(-32768);  send_window(127, TAPS, -1, 1'b0, 1'b1);
        repeat (3) @(negedge clock);

        // Back-pressure: result held for five cycles with in_ready low.
        out_ready = 1'b0;
        fill(20); send_window(0, TAPS, -1, 1'b0, 1'b1);
        wait_valid("hold_wait_valid");
        repeat (5) begin
            @(negedge clock);
            check_val("backpressure_in_ready", int'(in_ready), 0);
            check_val("backpressure_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        fill(16); send_window(0, TAPS, -1, 1'b0, 1'b1);
        repeat (3) @(negedge clock);

        // Reset mid-window drops the partial sum.
        fill(100); send_window(5, 4, -1, 1'b0, 1'b0);
        check_val("partial_tap_cnt", int'(tap_cnt), 4);
        aclr = 1'b1;
        @(negedge clock);
        aclr = 1'b0;
        check_val("midrst_tap_cnt", int'(tap_cnt), 0);
        check_val("midrst_in_ready", int'(in_ready), 1);
        check_val("midrst_out_valid", int'(out_valid), 0);
        fill(16); send_window(0, TAPS, -1, 1'b0, 1'b1);
        repeat (3) @(negedge clock);

        // Clock-enable stall mid-window stretches latency by three.
        fill(16); send_window(0, TAPS, 4, 1'b0, 1'b1);
        repeat (3) @(negedge clock);

        // Random values, random bias, random gaps in prod_valid.
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < TAPS; i++) win[i] = int'($urandom_range(0, 4000)) - 2000;
            b = int'($urandom_range(0, 255)) - 128;
            send_window(b, TAPS, -1, 1'b1, 1'b1);
        end
        repeat (3) @(negedge clock);

        // Reset while holding a result clears the pending output.
        out_ready = 1'b0;
        fill(48); send_window(-3, TAPS, -1, 1'b0, 1'b1);
        wait_valid("rsthold_wait_valid");
        @(negedge clock);
        aclr = 1'b1;
        @(negedge clock);
        aclr = 1'b0;
        check_val("rsthold_out_valid", int'(out_valid), 0);
        check_val("rsthold_out_data", int'(out_data), 0);
        check_val("rsthold_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;

        repeat (5) @(negedge clock);
        check_val("sb_empty", sb.size(), 0);
        check_val("output_count", n_out, n_exp_out);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
